// File: rtl/multicycle_step_sequencer_if.sv
// Instruction, flag, memory-ready and strobe bundle between the step sequencer
// (master) and the datapath it drives (slave).
interface multicycle_step_sequencer_if;
    logic [4:0] InsM;
    logic [2:0] InsCond;
    logic [1:0] InsL;
    logic       FlagC;
    logic       FlagZ;
    logic       Mem_Ready;
    logic [2:0] Cnt;
    logic       Buff_PC;
    logic       IR_Load;
    logic       PC_Inc;
    logic       PC_Load;
    logic       Reg_Write;
    logic       Mem_Read;
    logic       Mem_Write;
    logic       Flag_Write;
    logic       Link_Write;
    logic       Out_En;
    logic       Halted;
    logic       Illegal;
    logic       Mem_Err;

    modport master (
        input  InsM, InsCond, InsL, FlagC, FlagZ, Mem_Ready,
        output Cnt, Buff_PC, IR_Load, PC_Inc, PC_Load, Reg_Write, Mem_Read,
               Mem_Write, Flag_Write, Link_Write, Out_En, Halted, Illegal, Mem_Err
    );

    modport slave (
        output InsM, InsCond, InsL, FlagC, FlagZ, Mem_Ready,
        input  Cnt, Buff_PC, IR_Load, PC_Inc, PC_Load, Reg_Write, Mem_Read,
               Mem_Write, Flag_Write, Link_Write, Out_En, Halted, Illegal, Mem_Err
    );
endinterface

// File: rtl/multicycle_step_sequencer.sv
// Step sequencer for the multicycle core: owns Cnt, latches the instruction class
// at step 1 and emits per-step strobes. MULTICYCLE_ILLEGAL_TRAP_EN makes illegal opcodes halt.
module multicycle_step_sequencer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                          clk,
    input  logic                          Rst,
    multicycle_step_sequencer_if.master   bus
);
    localparam logic [3:0] CL_NOP  = 4'd0;
    localparam logic [3:0] CL_MOVI = 4'd1;
    localparam logic [3:0] CL_ALU  = 4'd2;
    localparam logic [3:0] CL_CMP  = 4'd3;
    localparam logic [3:0] CL_LDR  = 4'd4;
    localparam logic [3:0] CL_STR  = 4'd5;
    localparam logic [3:0] CL_JMP  = 4'd6;
    localparam logic [3:0] CL_JAL  = 4'd7;
    localparam logic [3:0] CL_BCC  = 4'd8;
    localparam logic [3:0] CL_BAL  = 4'd9;
    localparam logic [3:0] CL_OUT  = 4'd10;
    localparam logic [3:0] CL_HLT  = 4'd11;
    localparam logic [3:0] CL_ILL  = 4'd12;

    logic [2:0] r_cnt;
    logic [3:0] r_class;
    logic [2:0] r_cond;
    logic [7:0] r_wait;
    logic       r_halted;
    logic       r_mem_err;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    logic       r_illegal;
`endif

    logic [3:0] w_dec_class;
    logic [2:0] w_last_step;
    logic       w_active, w_c2, w_c3, w_c4;
    logic       w_mem_step, w_timeout, w_stall, w_last, w_taken;

    always_comb begin
        w_dec_class = CL_ILL;
        case (bus.InsM)
            5'b00000, 5'b00111, 5'b01000: w_dec_class = CL_ALU;
            5'b00001, 5'b00010, 5'b01011: w_dec_class = CL_MOVI;
            5'b00011, 5'b00100:           w_dec_class = CL_LDR;
            5'b00101:                     w_dec_class = CL_STR;
            5'b00110: begin
                if (bus.InsL == 2'b00)      w_dec_class = CL_STR;
                else if (bus.InsL == 2'b01) w_dec_class = CL_CMP;
            end
            5'b10000, 5'b10011:           w_dec_class = CL_JMP;
            5'b10001, 5'b10010:           w_dec_class = CL_JAL;
            5'b11000:                     w_dec_class = CL_BCC;
            5'b11001:                     w_dec_class = CL_BAL;
            5'b11100: begin
                if (bus.InsL == 2'b00)      w_dec_class = CL_OUT;
                else if (bus.InsL == 2'b01) w_dec_class = CL_HLT;
            end
            default:                      w_dec_class = CL_ILL;
        endcase
    end

    always_comb begin
        w_last_step = 3'd2;
        case (r_class)
            CL_ALU, CL_STR, CL_JAL: w_last_step = 3'd3;
            CL_LDR:                 w_last_step = 3'd4;
            default:                w_last_step = 3'd2;
        endcase
    end

    always_comb begin
        w_taken = 1'b0;
        case (r_cond)
            3'b000:  w_taken = !bus.FlagZ;
            3'b001:  w_taken = bus.FlagZ;
            3'b010:  w_taken = bus.FlagC;
            3'b011:  w_taken = !bus.FlagC;
            default: w_taken = 1'b0;
        endcase
    end

    // Reset also gates strobes so an aborted instruction drops everything at once
    assign w_active   = !Rst && !r_halted;
    assign w_c2       = w_active && (r_cnt == 3'd2);
    assign w_c3       = w_active && (r_cnt == 3'd3);
    assign w_c4       = w_active && (r_cnt == 3'd4);
    assign w_mem_step = (r_cnt == 3'd3) && ((r_class == CL_LDR) || (r_class == CL_STR));
    assign w_timeout  = (MEM_TIMEOUT != 0) && (r_wait == 8'(MEM_TIMEOUT - 1));
    assign w_stall    = w_mem_step && !bus.Mem_Ready && !w_timeout;
    assign w_last     = (r_cnt >= 3'd2) && (r_cnt >= w_last_step);

    assign bus.Cnt        = r_cnt;
    assign bus.IR_Load    = w_active && (r_cnt == 3'd0);
    assign bus.PC_Inc     = w_active && (r_cnt == 3'd0);
    assign bus.PC_Load    = (w_c2 && ((r_class == CL_JMP) || (r_class == CL_BAL) ||
                                      ((r_class == CL_BCC) && w_taken)))
                          || (w_c3 && (r_class == CL_JAL));
    assign bus.Reg_Write  = (w_c2 && (r_class == CL_MOVI)) || (w_c3 && (r_class == CL_ALU))
                          || (w_c4 && (r_class == CL_LDR));
    assign bus.Mem_Read   = w_c3 && (r_class == CL_LDR);
    assign bus.Mem_Write  = w_c3 && (r_class == CL_STR);
    assign bus.Flag_Write = w_c2 && ((r_class == CL_ALU) || (r_class == CL_CMP));
    assign bus.Link_Write = w_c2 && (r_class == CL_JAL);
    assign bus.Out_En     = w_c2 && (r_class == CL_OUT);
    assign bus.Halted     = r_halted;
    assign bus.Mem_Err    = r_mem_err;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    assign bus.Buff_PC    = w_active && w_last && !w_stall && (r_class != CL_ILL);
    assign bus.Illegal    = r_illegal;
`else
    assign bus.Buff_PC    = w_active && w_last && !w_stall;
    assign bus.Illegal    = w_c2 && (r_class == CL_ILL);
`endif

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            r_cnt     <= 3'd0;
            r_class   <= CL_NOP;
            r_cond    <= 3'd0;
            r_wait    <= 8'd0;
            r_halted  <= 1'b0;
            r_mem_err <= 1'b0;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
            r_illegal <= 1'b0;
`endif
        end else if (!r_halted) begin
            if (r_cnt == 3'd1) begin
                r_class <= w_dec_class;
                r_cond  <= bus.InsCond;
            end
            if (w_stall) begin
                r_wait <= r_wait + 8'd1;
            end else begin
                r_wait <= 8'd0;
                r_cnt  <= w_last ? 3'd0 : r_cnt + 3'd1;
            end
            // A timed-out access still completes the step, but leaves a sticky mark
            if (w_mem_step && !bus.Mem_Ready && w_timeout)
                r_mem_err <= 1'b1;
            if ((r_cnt == 3'd2) && (r_class == CL_HLT))
                r_halted <= 1'b1;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
            if ((r_cnt == 3'd2) && (r_class == CL_ILL)) begin
                r_halted  <= 1'b1;
                r_illegal <= 1'b1;
            end
`endif
        end
    end
endmodule

// File: tb/tb_multicycle_step_sequencer.sv
// Directed bench for multicycle_step_sequencer; observation word is
// {Mem_Err, Illegal, Halted, Cnt[2:0], IR,PCI,PCL,RW,MR,MW,FW,LW,OE,BuffPC}.
module tb_multicycle_step_sequencer;
    localparam logic [9:0] IR = 10'h200, PCI = 10'h100, PCL = 10'h080, RW = 10'h040;
    localparam logic [9:0] MR = 10'h020, MW = 10'h010, FW = 10'h008, LW = 10'h004;
    localparam logic [9:0] OE = 10'h002, BP = 10'h001;
    localparam logic [9:0] F0 = IR | PCI;

    logic clk;
    logic Rst;
    int   n_vec;
    int   n_err;
    logic [15:0] obs [0:31];
    logic [15:0] exp_v [0:31];

    multicycle_step_sequencer_if bus();

    multicycle_step_sequencer #(.MEM_TIMEOUT(15)) dut (
        .clk (clk),
        .Rst (Rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] pack();
        return {bus.Mem_Err, bus.Illegal, bus.Halted, bus.Cnt,
                bus.IR_Load, bus.PC_Inc, bus.PC_Load, bus.Reg_Write, bus.Mem_Read,
                bus.Mem_Write, bus.Flag_Write, bus.Link_Write, bus.Out_En, bus.Buff_PC};
    endfunction

    function automatic logic [15:0] ev(input logic [2:0] f, input logic [2:0] c, input logic [9:0] s);
        return {f, c, s};
    endfunction

    // Drive one instruction for n cycles, recording the outputs of each cycle.
    task automatic exec(input logic [4:0] m, input logic [1:0] l, input logic [2:0] c,
                        input logic fc, input logic fz, input logic [31:0] rdy, input int n);
        bus.InsM = m; bus.InsL = l; bus.InsCond = c; bus.FlagC = fc; bus.FlagZ = fz;
        for (int i = 0; i < n; i++) begin
            bus.Mem_Ready = rdy[i];
            #1;
            obs[i] = pack();
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        Rst = 1'b1;
        @(posedge clk);
        #1;
        Rst = 1'b0;
        bus.Mem_Ready = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        bus.InsM = 5'b00000; bus.InsL = 2'b00; bus.InsCond = 3'b000;
        bus.FlagC = 1'b0; bus.FlagZ = 1'b0; bus.Mem_Ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if (pack() !== 16'h0000) begin
            n_err++; $display("FAIL reset_outputs got %h want %h", pack(), 16'h0000);
        end
        Rst = 1'b0;
        bus.Mem_Ready = 1'b1;
        #1;
        n_vec++;
        if (pack() !== ev(3'b000, 3'd0, F0)) begin
            n_err++; $display("FAIL reset_release got %h want %h", pack(), ev(3'b000, 3'd0, F0));
        end
    endtask

    task automatic test_lhi();
        exec(5'b00001, 2'b00, 3'b000, 1'b0, 1'b0, '1, 3);
        exp_v[0] = ev(0, 0, F0); exp_v[1] = ev(0, 1, 0); exp_v[2] = ev(0, 2, RW | BP);
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (obs[i] !== exp_v[i]) begin
                n_err++; $display("FAIL lhi step%0d got %h want %h", i, obs[i], exp_v[i]);
            end
        end
        n_vec++;
        if (pack() !== ev(0, 0, F0)) begin
            n_err++; $display("FAIL lhi_next_fetch got %h want %h", pack(), ev(0, 0, F0));
        end
    endtask

    task automatic test_alu_cmp();
        exec(5'b00000, 2'b00, 3'b000, 1'b0, 1'b0, '1, 4);
        exp_v[0] = ev(0, 0, F0); exp_v[1] = ev(0, 1, 0);
        exp_v[2] = ev(0, 2, FW); exp_v[3] = ev(0, 3, RW | BP);
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (obs[i] !== exp_v[i]) begin
                n_err++; $display("FAIL add step%0d got %h want %h", i, obs[i], exp_v[i]);
            end
        end
        exec(5'b00110, 2'b01, 3'b000, 1'b0, 1'b0, '1, 3);
        exp_v[0] = ev(0, 0, F0); exp_v[1] = ev(0, 1, 0); exp_v[2] = ev(0, 2, FW | BP);
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (obs[i] !== exp_v[i]) begin
                n_err++; $display("FAIL cmp step%0d got %h want %h", i, obs[i], exp_v[i]);
            end
        end
    endtask

    task automatic test_mem();
        exec(5'b00101, 2'b00, 3'b000, 1'b0, 1'b0, '1, 4);
        exp_v[0] = ev(0, 0, F0); exp_v[1] = ev(0, 1, 0);
        exp_v[2] = ev(0, 2, 0);  exp_v[3] = ev(0, 3, MW | BP);
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (obs[i] !== exp_v[i]) begin
                n_err++; $display("FAIL str step%0d got %h want %h", i, obs[i], exp_v[i]);
            end
        end
        // Ready low on the first three step-3 cycles, high on the fourth
        exec(5'b00011, 2'b00, 3'b000, 1'b0, 1'b0, 32'h0000_00C0, 8);
        exp_v[0] = ev(0, 0, F0); exp_v[1] = ev(0, 1, 0); exp_v[2] = ev(0, 2, 0);
        for (int i = 3; i < 7; i++) exp_v[i] = ev(0, 3, MR);
        exp_v[7] = ev(0, 4, RW | BP);
        for (int i = 0; i < 8; i++) begin
            n_vec++;
            if (obs[i] !== exp_v[i]) begin
                n_err++; $display("FAIL ldr_wait step%0d got %h want %h", i, obs[i], exp_v[i]);
            end
        end
        // Ready stuck low: fifteen cycles at step 3, then forced completion
        exec(5'b00100, 2'b00, 3'b000, 1'b0, 1'b0, 32'h0, 19);
        exp_v[0] = ev(0, 0, F0); exp_v[1] = ev(0, 1, 0); exp_v[2] = ev(0, 2, 0);
        for (int i = 3; i < 18; i++) exp_v[i] = ev(0, 3, MR);
        exp_v[18] = ev(3'b100, 4, RW | BP);
        for (int i = 0; i < 19; i++) begin
            n_vec++;
            if (obs[i] !== exp_v[i]) begin
                n_err++; $display("FAIL ldr_timeout step%0d got %h want %h", i, obs[i], exp_v[i]);
            end
        end
        n_vec++;
        if (pack() !== ev(3'b100, 0, F0)) begin
            n_err++; $display("FAIL mem_err_sticky got %h want %h", pack(), ev(3'b100, 0, F0));
        end
        do_reset();
    endtask

    task automatic test_branch();
        logic [4:0]  bm [0:5];
        logic [1:0]  bl [0:5];
        logic [2:0]  bc [0:5];
        logic [1:0]  bf [0:5];
        logic [9:0]  s2 [0:5];
        logic [9:0]  s3 [0:5];
        int          bn [0:5];
        // BEQ Z=1, BNE Z=1, BCC C=0, BAL no flags, JAL, OutR
        bm[0] = 5'b11000; bl[0] = 0; bc[0] = 3'b001; bf[0] = 2'b01; s2[0] = PCL | BP; s3[0] = 0;  bn[0] = 3;
        bm[1] = 5'b11000; bl[1] = 0; bc[1] = 3'b000; bf[1] = 2'b01; s2[1] = BP;       s3[1] = 0;  bn[1] = 3;
        bm[2] = 5'b11000; bl[2] = 0; bc[2] = 3'b011; bf[2] = 2'b00; s2[2] = PCL | BP; s3[2] = 0;  bn[2] = 3;
        bm[3] = 5'b11001; bl[3] = 0; bc[3] = 3'b111; bf[3] = 2'b00; s2[3] = PCL | BP; s3[3] = 0;  bn[3] = 3;
        bm[4] = 5'b10001; bl[4] = 0; bc[4] = 3'b000; bf[4] = 2'b00; s2[4] = LW;       s3[4] = PCL | BP; bn[4] = 4;
        bm[5] = 5'b11100; bl[5] = 0; bc[5] = 3'b000; bf[5] = 2'b00; s2[5] = OE | BP;  s3[5] = 0;  bn[5] = 3;
        for (int k = 0; k < 6; k++) begin
            exec(bm[k], bl[k], bc[k], bf[k][1], bf[k][0], '1, bn[k]);
            exp_v[0] = ev(0, 0, F0); exp_v[1] = ev(0, 1, 0);
            exp_v[2] = ev(0, 2, s2[k]); exp_v[3] = ev(0, 3, s3[k]);
            for (int i = 0; i < bn[k]; i++) begin
                n_vec++;
                if (obs[i] !== exp_v[i]) begin
                    n_err++; $display("FAIL branch%0d step%0d got %h want %h", k, i, obs[i], exp_v[i]);
                end
            end
        end
    endtask

    task automatic test_halt();
        exec(5'b11100, 2'b01, 3'b000, 1'b0, 1'b0, '1, 13);
        exp_v[0] = ev(0, 0, F0); exp_v[1] = ev(0, 1, 0); exp_v[2] = ev(0, 2, BP);
        for (int i = 3; i < 13; i++) exp_v[i] = ev(3'b001, 0, 0);
        for (int i = 0; i < 13; i++) begin
            n_vec++;
            if (obs[i] !== exp_v[i]) begin
                n_err++; $display("FAIL halt step%0d got %h want %h", i, obs[i], exp_v[i]);
            end
        end
        Rst = 1'b1;
        #1;
        n_vec++;
        if (pack() !== 16'h0000) begin
            n_err++; $display("FAIL halt_rst got %h want %h", pack(), 16'h0000);
        end
        Rst = 1'b0;
        #1;
        n_vec++;
        if (pack() !== ev(0, 0, F0)) begin
            n_err++; $display("FAIL halt_resume got %h want %h", pack(), ev(0, 0, F0));
        end
    endtask

    task automatic test_illegal();
        exec(5'b11111, 2'b00, 3'b000, 1'b0, 1'b0, '1, 3);
        exp_v[0] = ev(0, 0, F0); exp_v[1] = ev(0, 1, 0);
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
        exp_v[2] = ev(3'b000, 2, 0);
        exp_v[3] = ev(3'b011, 0, 0);
`else
        exp_v[2] = ev(3'b010, 2, BP);
        exp_v[3] = ev(3'b000, 0, F0);
`endif
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (obs[i] !== exp_v[i]) begin
                n_err++; $display("FAIL illegal step%0d got %h want %h", i, obs[i], exp_v[i]);
            end
        end
        n_vec++;
        if (pack() !== exp_v[3]) begin
            n_err++; $display("FAIL illegal_after got %h want %h", pack(), exp_v[3]);
        end
        do_reset();
    endtask

    task automatic test_reset_mid_ldr();
        exec(5'b00011, 2'b00, 3'b000, 1'b0, 1'b0, 32'h0, 4);
        n_vec++;
        if (obs[3] !== ev(0, 3, MR)) begin
            n_err++; $display("FAIL midldr_pre got %h want %h", obs[3], ev(0, 3, MR));
        end
        Rst = 1'b1;
        #1;
        n_vec++;
        if (pack() !== 16'h0000) begin
            n_err++; $display("FAIL midldr_async got %h want %h", pack(), 16'h0000);
        end
        @(posedge clk);
        #1;
        n_vec++;
        if (pack() !== 16'h0000) begin
            n_err++; $display("FAIL midldr_held got %h want %h", pack(), 16'h0000);
        end
        Rst = 1'b0;
        bus.Mem_Ready = 1'b1;
        #1;
        // A fresh LDR must see no leftover wait count
        exec(5'b00011, 2'b00, 3'b000, 1'b0, 1'b0, '1, 5);
        exp_v[0] = ev(0, 0, F0); exp_v[1] = ev(0, 1, 0); exp_v[2] = ev(0, 2, 0);
        exp_v[3] = ev(0, 3, MR); exp_v[4] = ev(0, 4, RW | BP);
        for (int i = 0; i < 5; i++) begin
            n_vec++;
            if (obs[i] !== exp_v[i]) begin
                n_err++; $display("FAIL midldr_after step%0d got %h want %h", i, obs[i], exp_v[i]);
            end
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_lhi();
        test_alu_cmp();
        test_mem();
        test_branch();
        test_halt();
        test_illegal();
        test_reset_mid_ldr();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/multicycle_step_sequencer.md
Name: multicycle_step_sequencer

Overview:
- Central step sequencer for the multicycle RISC core. It owns the step counter Cnt, latches the instruction class from InsM/InsL/InsCond, and emits per-step datapath strobes.
- Buff_PC is asserted on the final step of each instruction.
- The existing per-signal decode blocks (OprandB, Buff_PC, etc.) consume this block's Cnt.
- Memory steps stall on a ready handshake with a bounded timeout; HLT freezes the core until reset.

Parameters:
- MEM_TIMEOUT, 15: maximum wait cycles on a memory step before forcing completion with Mem_Err. 0 means wait forever. Range 0..255.

Ports:
- clk  in  1  system clock, rising edge.
- Rst  in  1  asynchronous, active-high reset.
- InsM  in  5  instruction bits [15:11], valid while Cnt==1.
- InsCond  in  3  instruction bits [10:8], the branch condition.
- InsL  in  2  instruction bits [1:0].
- FlagC  in  1  carry flag from the ALU flag register.
- FlagZ  in  1  zero flag from the ALU flag register.
- Mem_Ready  in  1  memory completes the current access this cycle.
- Cnt  out  3  current step number.
- Buff_PC  out  1  last step of the instruction; Cnt returns to 0 next edge.
- IR_Load  out  1  load the instruction register.
- PC_Inc  out  1  PC+1.
- PC_Load  out  1  load PC from the target.
- Reg_Write  out  1  register file write.
- Mem_Read  out  1  data memory read.
- Mem_Write  out  1  data memory write.
- Flag_Write  out  1  update C/Z.
- Link_Write  out  1  write return address (JAL).
- Out_En  out  1  OutR strobe.
- Halted  out  1  core halted.
- Illegal  out  1  illegal opcode latched.
- Mem_Err  out  1  memory timeout occurred, sticky.

Behaviour:
- Reset: Cnt=0, class=NOP, wait counter=0. All strobes, Halted, Illegal and Mem_Err are 0. Rst mid-instruction aborts immediately; Cnt=0 on the first edge after release.
- Step 0, fetch: IR_Load=1, PC_Inc=1.
- Step 1, decode: class register loads from InsM/InsL/InsCond on the rising edge where Cnt==1. From step 2 onward only the latched class is used.
- Opcode decode (InsM, InsL):
  - 00000: ALU op (ADD/ADC/SUB/SBB by InsL).
  - 00001: LHI. 00010: LLI. 01011: MOV.
  - 00011, 00100: LDR.
  - 00101: STR. 00110 with InsL=00: STR.
  - 00110 with InsL=01: CMP.
  - 00111: ADDI. 01000: SUBI.
  - 10000: JMP. 10011: JR.
  - 10001, 10010: JAL.
  - 11000: Bcc. 11001: BAL.
  - 11100 with InsL=00: OutR. 11100 with InsL=01: HLT.
  - Anything else: illegal.
- Per-class steps (last step in brackets):
  - LHI/LLI/MOV: Reg_Write@2 [2].
  - ALU/ADDI/SUBI: Flag_Write@2, Reg_Write@3 [3].
  - CMP: Flag_Write@2 [2].
  - LDR: Mem_Read@3, Reg_Write@4 [4].
  - STR: Mem_Write@3 [3].
  - JMP/JR: PC_Load@2 [2].
  - JAL: Link_Write@2, PC_Load@3 [3].
  - Bcc: PC_Load@2 only if taken [2]. Conditions: InsCond 000 taken if !Z, 001 if Z, 010 if C, 011 if !C; other codes not taken. BAL is always taken.
  - OutR: Out_En@2 [2].
  - HLT: step 2 [2]; Halted=1 on that edge.
- Outputs are combinational from (Cnt, class). PC_Load for Bcc is additionally combinational from the flags during step 2.
- Memory handshake at step 3 for LDR and STR:
  - Mem_Read/Mem_Write stay asserted and Cnt holds while Mem_Ready=0.
  - Cnt advances on the edge with Mem_Ready=1.
  - With MEM_TIMEOUT>0, after MEM_TIMEOUT consecutive wait cycles the step completes anyway and Mem_Err sets (sticky until Rst).
  - The wait counter clears on each step advance.
- Buff_PC=1 on the last step, when not stalled. The next edge sets Cnt=0. Otherwise Cnt increments by 1. Cnt never exceeds 4.
- Halted state: Cnt held at 0, every strobe including IR_Load and Buff_PC is 0. Only Rst exits.
- Illegal opcode: behaviour is set by the optional feature below.

Optional Feature:
- Macro: MULTICYCLE_ILLEGAL_TRAP_EN.
- Defined: an illegal class sets Illegal=1 and Halted=1 on the step-2 edge; no strobes at step 2.
- Undefined: an illegal class executes as a NOP with last step 2 and no strobes. Illegal pulses high during step 2 only; Halted is unaffected.

Test Plan:
- Reset, then LHI (InsM=00001) -> Cnt 0,1,2,0. IR_Load@0, Reg_Write@2, Buff_PC@2. Next IR_Load one cycle later.
- ADD (00000, InsL=00) then CMP (00110, InsL=01) -> ADD: Flag_Write@2, Reg_Write@3, Buff_PC@3. CMP: Flag_Write@2, Buff_PC@2, no Reg_Write.
- LDR with Mem_Ready low for 3 cycles, MEM_TIMEOUT=15 -> Cnt holds at 3 for 4 cycles, Mem_Read high throughout, then Reg_Write@4. Mem_Err=0. Repeat with Mem_Ready stuck low -> advance after 15 wait cycles, Mem_Err=1.
- Branch checks -> BEQ (11000, InsCond=001) with Z=1: PC_Load@2. BNE with Z=1: no PC_Load. BCC with C=0: PC_Load. BAL: PC_Load regardless of flags.
- HLT (11100, InsL=01) -> Halted=1 after step 2. Cnt stays 0 and IR_Load stays 0 for 10 cycles. Rst pulse clears Halted, then fetch resumes.
- Illegal InsM=11111 -> with the macro: Illegal=1 and Halted=1. Without it: 3-step NOP with Illegal pulsing at step 2. Rst asserted at step 3 of an LDR -> all outputs 0 asynchronously.
